// File: rtl/pll_rst_seq.sv
// pll_rst_seq: qualifies the PLL lock flag, holds N_RST downstream resets until
// lock has been stable for LOCK_STABLE cycles, releases them one by one every
// STAGGER cycles, and drops them all again (counting the event) on lock loss.
module pll_rst_seq #(
    parameter int unsigned N_RST       = 4,
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned STAGGER     = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic [N_RST-1:0] rst_out_n,
    output logic             seq_done,
    output logic             lock_lost_pulse,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    localparam int unsigned STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int unsigned STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IDX_W  = (N_RST > 1) ? $clog2(N_RST) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [1:0]        sync_q;
    logic              locked_s;
    state_t            state, state_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_nxt;
    logic [STG_W-1:0]  stg_cnt, stg_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [N_RST-1:0]  rst_nxt;
    logic              done_nxt;
    logic              pulse_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              loss;

    assign locked_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // State, counter and output registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            stab_cnt        <= '0;
            stg_cnt         <= '0;
            idx             <= '0;
            rst_out_n       <= '0;
            seq_done        <= 1'b0;
            lock_lost_pulse <= 1'b0;
            lock_lost_cnt   <= '0;
        end else begin
            state           <= state_nxt;
            stab_cnt        <= stab_nxt;
            stg_cnt         <= stg_nxt;
            idx             <= idx_nxt;
            rst_out_n       <= rst_nxt;
            seq_done        <= done_nxt;
            lock_lost_pulse <= pulse_nxt;
            lock_lost_cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-output logic; lock loss after first release overrides all
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        stg_nxt   = stg_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out_n;
        done_nxt  = seq_done;
        pulse_nxt = 1'b0;
        cnt_nxt   = lock_lost_cnt;
        loss      = 1'b0;

        case (state)
            WAIT_LOCK: begin
                rst_nxt  = '0;
                done_nxt = 1'b0;
                if (locked_s) begin
                    state_nxt = STABLE;
                    stab_nxt  = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    // Lock dropped before any release: just start qualifying again
                    state_nxt = WAIT_LOCK;
                    stab_nxt  = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    rst_nxt[0] = 1'b1;
                    idx_nxt    = '0;
                    stg_nxt    = '0;
                    stab_nxt   = '0;
                    if (N_RST == 1) begin
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else begin
                    stab_nxt = stab_cnt + STAB_W'(1);
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    loss = 1'b1;
                end else if (stg_cnt == STG_LAST) begin
                    stg_nxt = '0;
                    idx_nxt = idx + IDX_W'(1);
                    for (int i = 0; i < int'(N_RST); i++) begin
                        if (i == int'(idx) + 1) begin
                            rst_nxt[i] = 1'b1;
                        end
                    end
                    if (int'(idx) + 1 == int'(N_RST) - 1) begin
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                    end
                end else begin
                    stg_nxt = stg_cnt + STG_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    loss = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                rst_nxt   = '0;
                done_nxt  = 1'b0;
            end
        endcase

        if (loss) begin
            state_nxt = WAIT_LOCK;
            rst_nxt   = '0;
            done_nxt  = 1'b0;
            pulse_nxt = 1'b1;
            stab_nxt  = '0;
            stg_nxt   = '0;
            idx_nxt   = '0;
            if (lock_lost_cnt != CNT_MAX) begin
                cnt_nxt = lock_lost_cnt + CNT_W'(1);
            end
        end
    end

endmodule
